// File: rtl/rate_adapt_ctrl.sv
// rate_adapt_ctrl: drains MAC/PHY traffic, switches rate-adapter speed and generates the sampling strobe.
module rate_adapt_ctrl #(
  parameter int IDLE_CYC = 12,
  parameter int SETTLE_CYC = 16,
  parameter int DRAIN_TMO = 65535,
  parameter logic [1:0] RST_SPEED = 2'b10
) (
  input  logic       i_GClk,
  input  logic       i_Rst,
  input  logic [1:0] i2_SpeedReq,
  input  logic       i_TxActive,
  input  logic       i_RxActive,
  output logic [1:0] o2_Speed,
  output logic       o_SamplingClk,
  output logic       o_TxHold,
  output logic       o_Busy,
  output logic       o_SpeedChg,
  output logic       o_Forced
);
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int DW = $clog2(DRAIN_TMO + 1);
  typedef enum logic [1:0] {RUN, DRAIN, SWITCH, SETTLE} state_t;
  state_t r_state, w_nxt;
  logic [IW-1:0] r_idle;
  logic [SW-1:0] r_set;
  logic [DW-1:0] r_dcnt;
  logic [6:0] r_div, w_div_nxt, w_n;
  logic [1:0] r_target, w_target;
  logic w_valid, w_idle, w_idle_done, w_tmo, w_abort, w_cur_on, w_nxt_on;
  always_comb begin
    w_valid = i2_SpeedReq != 2'b11;
    w_target = w_valid ? i2_SpeedReq : r_target;
    w_idle = !(i_TxActive | i_RxActive);
    w_idle_done = w_idle && r_idle == IW'(IDLE_CYC - 1);
    w_tmo = r_dcnt == DW'(DRAIN_TMO - 1);
    w_abort = w_valid && i2_SpeedReq == o2_Speed;
    w_nxt = r_state;
    case (r_state)
      RUN:     w_nxt = (w_valid && !w_abort) ? DRAIN : RUN;
      DRAIN:   w_nxt = w_abort ? RUN : (w_idle_done || w_tmo) ? SWITCH : DRAIN;
      SWITCH:  w_nxt = SETTLE;
      default: w_nxt = (r_set == SW'(SETTLE_CYC - 1)) ? RUN : SETTLE;
    endcase
    w_n = o2_Speed == 2'b00 ? 7'd100 : o2_Speed == 2'b01 ? 7'd10 : 7'd1;
    w_cur_on = r_state == RUN || r_state == DRAIN;
    w_nxt_on = w_nxt == RUN || w_nxt == DRAIN;
    // divider only advances while staying in RUN/DRAIN; any entry restarts at 0 so the first RUN cycle strobes
    w_div_nxt = (w_cur_on && w_nxt_on) ? ((r_div >= w_n - 7'd1) ? 7'd0 : r_div + 7'd1) : 7'd0;
  end
  always_ff @(posedge i_GClk) begin
    if (i_Rst) begin
      r_state <= SETTLE;
      r_target <= RST_SPEED;
      r_idle <= '0;
      r_set <= '0;
      r_dcnt <= '0;
      r_div <= '0;
      o2_Speed <= RST_SPEED;
      o_SamplingClk <= 1'b0;
      o_TxHold <= 1'b1;
      o_Busy <= 1'b1;
      o_SpeedChg <= 1'b0;
      o_Forced <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_valid) r_target <= i2_SpeedReq;
      r_idle <= (r_state == DRAIN && w_nxt == DRAIN && w_idle) ? ((r_idle == IW'(IDLE_CYC)) ? r_idle : r_idle + IW'(1)) : '0;
      r_dcnt <= (r_state == DRAIN && w_nxt == DRAIN) ? r_dcnt + DW'(1) : '0;
      r_set <= (r_state == SETTLE && w_nxt == SETTLE) ? r_set + SW'(1) : '0;
      r_div <= w_div_nxt;
      o_SamplingClk <= w_nxt_on && w_div_nxt == 7'd0;
      o_TxHold <= w_nxt != RUN;
      o_Busy <= w_nxt != RUN;
      o_SpeedChg <= w_nxt == SWITCH;
      if (w_nxt == SWITCH) o2_Speed <= w_target;
      if (r_state == DRAIN && w_nxt == SWITCH && !w_idle_done) o_Forced <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rate_adapt_ctrl.sv
// tb_rate_adapt_ctrl: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_rate_adapt_ctrl;
  localparam int IDLE = 12;
  localparam int SETTLE = 16;
  localparam int TMO = 1000;
  localparam logic [1:0] RSPD = 2'b10;
  logic clk = 1'b0, rst = 1'b1, tx = 1'b0, rx = 1'b0;
  logic [1:0] req = 2'b10;
  logic [1:0] spd;
  logic strobe, hold, busy, chg, forced;
  int asserts = 0, fails = 0;
  bit chk_en = 1'b0;
  rate_adapt_ctrl #(.IDLE_CYC(IDLE), .SETTLE_CYC(SETTLE), .DRAIN_TMO(TMO), .RST_SPEED(RSPD)) dut (
    .i_GClk(clk), .i_Rst(rst), .i2_SpeedReq(req), .i_TxActive(tx), .i_RxActive(rx),
    .o2_Speed(spd), .o_SamplingClk(strobe), .o_TxHold(hold), .o_Busy(busy),
    .o_SpeedChg(chg), .o_Forced(forced));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  // model: phase 0 run, 1 drain, 2 switch, 3 settle; strobes derived from cycles since RUN entry modulo N
  int m_ph, m_k, m_left, m_idle, m_age;
  logic [1:0] m_spd, m_tgt;
  bit m_forced;
  function automatic int div_of(input logic [1:0] s);
    return s == 2'b00 ? 100 : s == 2'b01 ? 10 : 1;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 3; m_left = SETTLE; m_spd = RSPD; m_tgt = RSPD; m_forced = 0; m_k = 0;
    end else begin
      if (req != 2'b11) m_tgt = req;
      if (m_ph == 0) begin
        m_k++;
        if (req != 2'b11 && req != m_spd) begin m_ph = 1; m_idle = 0; m_age = 0; end
      end else if (m_ph == 1) begin
        m_k++; m_age++;
        m_idle = (tx || rx) ? 0 : m_idle + 1;
        if (req != 2'b11 && req == m_spd) m_ph = 0;
        else if (m_idle >= IDLE) begin m_ph = 2; m_spd = m_tgt; end
        else if (m_age >= TMO) begin m_ph = 2; m_spd = m_tgt; m_forced = 1; end
      end else if (m_ph == 2) begin
        m_ph = 3; m_left = SETTLE;
      end else begin
        m_left--;
        if (m_left == 0) begin m_ph = 0; m_k = 0; end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("speed", spd, m_spd);
    chk("strobe", strobe, (m_ph <= 1 && m_k % div_of(m_spd) == 0) ? 1 : 0);
    chk("txhold", hold, m_ph != 0 ? 1 : 0);
    chk("busy", busy, m_ph != 0 ? 1 : 0);
    chk("speedchg", chg, m_ph == 2 ? 1 : 0);
    chk("forced", forced, m_forced);
  end
  function automatic bit hit(input int sel);
    return sel == 0 ? !busy : chg;
  endfunction
  task automatic wait_cnt(input int sel, input int max, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!hit(sel) && n < max);
  endtask
  task automatic count_strobes(input int cyc, output int s);
    s = strobe ? 1 : 0;
    repeat (cyc - 1) begin @(negedge clk); s += strobe ? 1 : 0; end
  endtask
  int n, s;
  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy, 1);
    chk("reset_speed", spd, 2);
    rst = 1'b0;
    wait_cnt(0, 60, n);
    chk("rst_to_run_cycles", n, 16);
    chk("gig_first_strobe", strobe, 1);
    chk("gig_txhold", hold, 0);
    count_strobes(20, s);
    chk("gig_strobe_const", s, 20);
    req = 2'b01;
    wait_cnt(1, 60, n);
    chk("drain_idle_cycles", n, 13);
    chk("speed_01_on_chg", spd, 1);
    wait_cnt(0, 60, n);
    chk("settle_cycles", n, 17);
    count_strobes(30, s);
    chk("m100_strobes_30", s, 3);
    tx = 1'b1; req = 2'b00;
    repeat (300) @(negedge clk);
    chk("hold_during_frame", hold, 1);
    tx = 1'b0;
    wait_cnt(1, 60, n);
    chk("frame_end_idle", n, 12);
    wait_cnt(0, 60, n);
    chk("settle_10m", n, 17);
    count_strobes(200, s);
    chk("m10_strobes_200", s, 2);
    rx = 1'b1; req = 2'b01;
    wait_cnt(1, 1100, n);
    chk("tmo_cycles", n, 1001);
    @(negedge clk);
    chk("forced_set", forced, 1);
    rx = 1'b0; req = 2'b10;
    wait_cnt(0, 60, n);
    wait_cnt(1, 60, n);
    chk("switch_after_forced", n, 13);
    wait_cnt(0, 60, n);
    chk("forced_sticky", forced, 1);
    req = 2'b01;
    repeat (3) @(negedge clk);
    req = 2'b10;
    s = 0;
    repeat (30) begin @(negedge clk); s += chg ? 1 : 0; end
    chk("abort_no_chg", s, 0);
    chk("abort_speed", spd, 2);
    chk("abort_run", busy, 0);
    req = 2'b11;
    s = 0;
    repeat (30) begin @(negedge clk); s += busy ? 1 : 0; end
    chk("reserved_ignored", s, 0);
    req = 2'b01;
    wait_cnt(1, 60, n);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midsettle_rst_speed", spd, 2);
    chk("midsettle_rst_forced", forced, 0);
    chk("midsettle_rst_busy", busy, 1);
    req = 2'b10; rst = 1'b0;
    wait_cnt(0, 60, n);
    chk("midsettle_rst_settle", n, 16);
    repeat (4000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 59) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) tx = ~tx;
      if ($urandom_range(0, 39) == 0) rx = ~rx;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
